// File: rtl/copro_pkg.sv
// -----------------------------------------------------------------------------
// copro_pkg
// Shared definitions for the coprocessor writeback slice: register-file
// geometry, the default result-buffer depth and the buffered entry format.
// -----------------------------------------------------------------------------
package copro_pkg;

    localparam int XLEN               = 32;
    localparam int REG_ADDR_W         = 5;
    localparam int NUM_REGS           = 1 << REG_ADDR_W;
    localparam int FIFO_DEPTH_DEFAULT = 2;

    // One buffered coprocessor result: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO of wb_entry_t used to hold coprocessor results until
// the register-file write port is free.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_entry at the tail (ignored while full)
//   push_entry in   entry to enqueue
//   pop        in   drop the head entry (ignored while empty)
//   full       out  occupancy == DEPTH
//   empty      out  occupancy == 0
//   head       out  oldest entry (valid only when !empty)
// -----------------------------------------------------------------------------
module wb_fifo
    import copro_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push, do_pop;

    // Fullness comes from the registered count only, so a pop in the same
    // cycle never frees room for a push.
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            // DEPTH is a power of two, so natural overflow wraps the pointer.
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/copro_writeback.sv
// -----------------------------------------------------------------------------
// copro_writeback
// Merges coprocessor (GCD/LCM) results into the single register-file write
// port shared with the main pipeline, and tracks which registers still await
// a coprocessor result.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   issue_valid/issue_rd/issue_ready   coprocessor issue handshake
//   res_valid/res_ready/res_rd/res_data  result handshake from datapath
//   core_we/core_rd/core_wd       main-pipeline writeback request (priority)
//   RegWrite/A3/WD                register-file write port
//   rs1/rs2 -> rs1_pending/rs2_pending  operand hazard lookup
//   waw_err                       sticky: core wrote a register still pending
// -----------------------------------------------------------------------------
module copro_writeback
    import copro_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [REG_ADDR_W-1:0] res_rd,
    input  logic [XLEN-1:0]       res_data,
    input  logic                  core_we,
    input  logic [REG_ADDR_W-1:0] core_rd,
    input  logic [XLEN-1:0]       core_wd,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [XLEN-1:0]       WD,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic                  waw_err
);

    logic                fifo_full, fifo_empty;
    logic                fifo_push, fifo_pop;
    wb_entry_t           fifo_head, res_entry;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                waw_err_q, waw_err_d;

    assign res_entry = '{rd: res_rd, data: res_data};

    // Handshakes are withheld during the reset cycle; the buffer drains only
    // when the core leaves the write port idle.
    assign res_ready   = !fifo_full && !reset;
    assign fifo_push   = res_valid && res_ready;
    assign fifo_pop    = !reset && !core_we && !fifo_empty;
    assign issue_ready = !reset && !pending_q[issue_rd];

    // Bit 0 is never set, so x0 always reads as not pending.
    assign rs1_pending = pending_q[rs1];
    assign rs2_pending = pending_q[rs2];
    assign waw_err     = waw_err_q;

    wb_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (res_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    // Write-port mux: core has absolute priority; a buffered result aimed at
    // x0 is presented but discarded (RegWrite stays low).
    always_comb begin
        RegWrite = 1'b0;
        A3       = '0;
        WD       = '0;
        if (core_we) begin
            RegWrite = 1'b1;
            A3       = core_rd;
            WD       = core_wd;
        end else if (fifo_pop) begin
            RegWrite = (fifo_head.rd != '0);
            A3       = fifo_head.rd;
            WD       = fifo_head.data;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d[fifo_head.rd] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        waw_err_d = waw_err_q
                  | (core_we && (core_rd != '0) && pending_q[core_rd]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            waw_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            waw_err_q <= waw_err_d;
        end
    end

endmodule

// File: tb/tb_copro_writeback.sv
module tb_copro_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_rd;
    logic [31:0] res_data;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_wd;
    logic        RegWrite;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [4:0]  rs1, rs2;
    logic        rs1_pending, rs2_pending;
    logic        waw_err;

    always #5 clk = ~clk;

    copro_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_rd      (res_rd),
        .res_data    (res_data),
        .core_we     (core_we),
        .core_rd     (core_rd),
        .core_wd     (core_wd),
        .RegWrite    (RegWrite),
        .A3          (A3),
        .WD          (WD),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .waw_err     (waw_err)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pend = '0;
    logic        m_waw  = 1'b0;

    task automatic check_model(input string tag);
        logic        e_rw, e_rr, e_ir;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        @(negedge clk);
        e_rw = 0; e_a3 = 0; e_wd = 0;
        if (reset) begin
            e_rr = 0;
            e_ir = 0;
        end else begin
            e_rr = (mq.size() < DEPTH);
            e_ir = !m_pend[issue_rd];
        end
        if (core_we) begin
            e_rw = 1; e_a3 = core_rd; e_wd = core_wd;
        end else if (!reset && mq.size() > 0) begin
            e_rw = (mq[0].rd != 0); e_a3 = mq[0].rd; e_wd = mq[0].data;
        end
        chk({tag, ".RegWrite"},  RegWrite,    e_rw);
        chk({tag, ".A3"},        A3,          e_a3);
        chk({tag, ".WD"},        WD,          e_wd);
        chk({tag, ".res_ready"}, res_ready,   e_rr);
        chk({tag, ".iss_ready"}, issue_ready, e_ir);
        chk({tag, ".rs1_pend"},  rs1_pending, m_pend[rs1]);
        chk({tag, ".rs2_pend"},  rs2_pending, m_pend[rs2]);
        chk({tag, ".waw_err"},   waw_err,     m_waw);
    endtask

    task automatic advance();
        logic [31:0] old;
        logic        was_full;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_pend = '0;
            m_waw  = 0;
        end else begin
            old      = m_pend;
            was_full = (mq.size() >= DEPTH);
            if (core_we && core_rd != 0 && old[core_rd]) m_waw = 1;
            if (!core_we && mq.size() > 0) begin
                m_pend[mq[0].rd] = 0;
                void'(mq.pop_front());
            end
            if (issue_valid && issue_rd != 0 && !old[issue_rd]) m_pend[issue_rd] = 1;
            if (res_valid && !was_full) mq.push_back('{res_rd, res_data});
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; issue_valid = 0; issue_rd = 0; res_valid = 0; res_rd = 0;
        res_data = 0; core_we = 0; core_rd = 0; core_wd = 0; rs1 = 0; rs2 = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rst; logic iv; logic [4:0] ird; logic rv; logic [4:0] rrd; logic [31:0] rdata;
        logic cwe; logic [4:0] crd; logic [31:0] cwd; logic [4:0] r1; logic [4:0] r2;
        logic e_rw; logic [4:0] e_a3; logic [31:0] e_wd; logic e_rr; logic e_ir;
        logic e_r1p; logic e_r2p; logic e_waw;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst iv ird rv rrd rdata        cwe crd cwd    r1 r2 | rw a3 wd          rr ir 1p 2p waw
        tbl[0]  = '{1, 0, 0, 0, 0, 0,           0, 0, 0,     0, 0,   0, 0, 0,           0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0,           1, 2, 'h11,  0, 0,   1, 2, 'h11,        0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 5, 0, 0, 0,           0, 0, 0,     5, 0,   0, 0, 0,           1, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 5, 1, 5, 6,           0, 0, 0,     5, 0,   0, 0, 0,           1, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0,           0, 0, 0,     5, 0,   1, 5, 6,           1, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0,           0, 0, 0,     5, 0,   0, 0, 0,           1, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 'hDEADBEEF,  0, 0, 0,     0, 0,   0, 0, 0,           1, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,           0, 0, 0,     0, 0,   0, 0, 'hDEADBEEF,  1, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0,           0, 0, 0,     0, 0,   0, 0, 0,           1, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 7, 0, 0, 0,           0, 0, 0,     0, 0,   0, 0, 0,           1, 1, 0, 0, 0};
        tbl[10] = '{0, 1, 7, 0, 0, 0,           0, 0, 0,     0, 7,   0, 0, 0,           1, 0, 0, 1, 0};
        tbl[11] = '{0, 1, 7, 1, 7, 'h15,        0, 0, 0,     0, 7,   0, 0, 0,           1, 0, 0, 1, 0};
        tbl[12] = '{0, 1, 7, 0, 0, 0,           0, 0, 0,     0, 7,   1, 7, 'h15,        1, 0, 0, 1, 0};
        tbl[13] = '{0, 1, 7, 0, 0, 0,           0, 0, 0,     0, 7,   0, 0, 0,           1, 1, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0,           0, 0, 0,     0, 7,   0, 0, 0,           1, 1, 0, 1, 0};
        tbl[15] = '{0, 1, 9, 0, 0, 0,           0, 0, 0,     0, 0,   0, 0, 0,           1, 1, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0,           1, 9, 'h99,  9, 0,   1, 9, 'h99,        1, 1, 1, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0,           0, 0, 0,     0, 7,   0, 0, 0,           1, 1, 0, 1, 1};
        tbl[18] = '{1, 0, 0, 0, 0, 0,           0, 0, 0,     9, 7,   0, 0, 0,           0, 0, 1, 1, 1};
        tbl[19] = '{0, 0, 0, 0, 0, 0,           0, 0, 0,     9, 7,   0, 0, 0,           1, 1, 0, 0, 0};

        // Bring state out of X before the table.
        idle();
        reset = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            reset = tbl[i].rst; issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
            res_valid = tbl[i].rv; res_rd = tbl[i].rrd; res_data = tbl[i].rdata;
            core_we = tbl[i].cwe; core_rd = tbl[i].crd; core_wd = tbl[i].cwd;
            rs1 = tbl[i].r1; rs2 = tbl[i].r2;
            @(negedge clk);
            chk($sformatf("vec%0d.RegWrite", i),  RegWrite,    tbl[i].e_rw);
            chk($sformatf("vec%0d.A3", i),        A3,          tbl[i].e_a3);
            chk($sformatf("vec%0d.WD", i),        WD,          tbl[i].e_wd);
            chk($sformatf("vec%0d.res_ready", i), res_ready,   tbl[i].e_rr);
            chk($sformatf("vec%0d.iss_ready", i), issue_ready, tbl[i].e_ir);
            chk($sformatf("vec%0d.rs1_pend", i),  rs1_pending, tbl[i].e_r1p);
            chk($sformatf("vec%0d.rs2_pend", i),  rs2_pending, tbl[i].e_r2p);
            chk($sformatf("vec%0d.waw_err", i),   waw_err,     tbl[i].e_waw);
            advance();
        end

        // Two results buffered behind a busy core port, third refused.
        idle(); core_we = 1; core_rd = 1; core_wd = 'hA1; res_valid = 1; res_rd = 3; res_data = 'h0C;
        check_model("q1"); advance();
        core_rd = 2; core_wd = 'hA2; res_rd = 4; res_data = 'h24;
        check_model("q2"); advance();
        core_rd = 6; core_wd = 'hA3; res_rd = 8; res_data = 'h77;
        check_model("q3"); chk("q3.full_ready", res_ready, 0); chk("q3.core_a3", A3, 6); chk("q3.core_wd", WD, 'hA3);
        advance();
        idle();
        check_model("q4"); chk("q4.a3", A3, 3); chk("q4.wd", WD, 'h0C); chk("q4.rw", RegWrite, 1); advance();
        check_model("q5"); chk("q5.a3", A3, 4); chk("q5.wd", WD, 'h24); advance();
        check_model("q6"); chk("q6.rw", RegWrite, 0); advance();

        // Reset with buffered results discards them.
        idle(); issue_valid = 1; issue_rd = 10;
        check_model("r1"); advance();
        idle(); core_we = 1; core_rd = 1; res_valid = 1; res_rd = 10; res_data = 'h100;
        check_model("r2"); advance();
        res_rd = 11; res_data = 'h200;
        check_model("r3"); advance();
        idle(); reset = 1; rs1 = 10;
        check_model("r4"); chk("r4.rw", RegWrite, 0); chk("r4.rs1p", rs1_pending, 1); advance();
        idle(); rs1 = 10;
        check_model("r5"); chk("r5.rw", RegWrite, 0); chk("r5.rr", res_ready, 1); chk("r5.rs1p", rs1_pending, 0);
        advance();
        idle();
        check_model("r6"); chk("r6.rw", RegWrite, 0); advance();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 500; n++) begin
            reset       = ($urandom_range(0, 59) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 15));
            res_valid   = $urandom_range(0, 1);
            res_rd      = 5'($urandom_range(0, 15));
            res_data    = $urandom;
            core_we     = ($urandom_range(0, 2) == 0);
            core_rd     = 5'($urandom_range(0, 15));
            core_wd     = $urandom;
            rs1         = 5'($urandom_range(0, 15));
            rs2         = 5'($urandom_range(0, 15));
            check_model($sformatf("rnd%0d", n));
            advance();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/copro_writeback.md
COPRO_WRITEBACK -- requirements
Module: copro_writeback

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of buffered coprocessor results (power of two, >=2).
REQ-002 Ports: clk  in  1  rising-edge clock for all state.
REQ-003 Ports: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: issue_valid  in  1  coprocessor (GCD/LCM) instruction issued this cycle.
REQ-005 Ports: issue_rd  in  5  destination register of issued instruction.
REQ-006 Ports: issue_ready  out  1  issue accepted this cycle.
REQ-007 Ports: res_valid  in  1 / res_ready  out  1  result handshake from coprocessor datapath.
REQ-008 Ports: res_rd  in  5 / res_data  in  32  result destination and value.
REQ-009 Ports: core_we  in  1 / core_rd  in  5 / core_wd  in  32  main-pipeline writeback request.
REQ-010 Ports: RegWrite  out  1 / A3  out  5 / WD  out  32  register-file write port.
REQ-011 Ports: rs1, rs2  in  5 / rs1_pending, rs2_pending  out  1  operand hazard lookup.
REQ-012 Ports: waw_err  out  1  sticky core-write-to-pending-register flag.

Function
REQ-013 Results SHALL be buffered in a FIFO_DEPTH-entry FIFO of {rd, data}; push when res_valid & res_ready.
REQ-014 res_ready SHALL equal !full (registered occupancy); no push when full, even if a pop occurs the same cycle.
REQ-015 Write-port mux SHALL be combinational: core_we=1 -> RegWrite=1, A3=core_rd, WD=core_wd (core has absolute priority).
REQ-016 core_we=0 & FIFO non-empty -> A3/WD = FIFO head; RegWrite=1 unless head rd==0; head popped at that clock edge.
REQ-017 core_we=0 & FIFO empty -> RegWrite=0, A3=0, WD=0.
REQ-018 Head entry with rd==0 SHALL be popped without a write (RegWrite=0).
REQ-019 Empty FIFO: incoming result SHALL NOT bypass to the write port; earliest write is cycle after push.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter range 0..FIFO_DEPTH; simultaneous push and pop leaves count unchanged.
REQ-021 Scoreboard: 32-bit pending vector; bit 0 hardwired 0.
REQ-022 issue_ready SHALL equal !pending[issue_rd]; accepted issue (valid & ready, rd!=0) sets pending[issue_rd] next cycle.
REQ-023 pending[rd] SHALL clear on the edge at which the FIFO head with that rd is popped.
REQ-024 Set and clear of same bit in one cycle cannot occur (blocked by REQ-022); set and clear of different bits SHALL both take effect.
REQ-025 rsN_pending SHALL be combinational pending[rsN]; 0 for rsN==0.
REQ-026 core_we=1 with core_rd!=0 and pending[core_rd]=1 SHALL set waw_err next cycle; waw_err holds until reset.
REQ-027 A result whose rd is not pending SHALL still be buffered and written (no check).

Reset
REQ-028 Reset SHALL be sampled on posedge clk only; asynchronous assertion has no effect until the edge.
REQ-029 On reset: FIFO emptied (pointers, count = 0), pending = 0, waw_err = 0.
REQ-030 During reset cycle: res_ready=0, issue_ready=0; write port follows core inputs only (RegWrite=core_we).
REQ-031 Reset mid-operation SHALL discard buffered results without writing them.

Structure
REQ-032 Package copro_pkg SHALL hold XLEN=32, REG_ADDR_W=5, default FIFO_DEPTH, and typedef wb_entry_t {rd, data}.
REQ-033 FIFO SHALL be sub-module wb_fifo (push/pop/full/empty/head); scoreboard and mux in copro_writeback.

Verification
REQ-034 Issue rd=5 -> rs1=5 gives rs1_pending=1; result {5, 0x00000006} with core_we=0 -> next cycle RegWrite=1, A3=5, WD=6; following cycle rs1_pending=0.
REQ-035 Two results {3,0x0C},{4,0x24} pushed with core_we held 1 for 3 cycles -> res_ready=0 after second push; core writes pass through; then rd 3 then rd 4 written on consecutive cycles in order.
REQ-036 Issue rd=7 twice back-to-back -> second cycle issue_ready=0; re-accepted only after result for 7 written.
REQ-037 Result {0, 0xDEADBEEF} -> popped, RegWrite=0, no pending change.
REQ-038 pending[9]=1, core_we=1 core_rd=9 -> waw_err=1 next cycle, persists until reset.
REQ-039 Two results buffered, reset asserted one cycle -> no write of buffered data; FIFO empty, all pending=0, res_ready=1 after reset deasserts.
